// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC sequencing controller: FSM state
// encoding, halt-cause codes and the default reset PC.
package npc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_FETCH_REQ  = 4'd1,
        ST_FETCH_WAIT = 4'd2,
        ST_DECODE     = 4'd3,
        ST_EXEC       = 4'd4,
        ST_MEM_REQ    = 4'd5,
        ST_MEM_WAIT   = 4'd6,
        ST_WB         = 4'd7,
        ST_HALT       = 4'd8
    } npc_state_e;

    localparam logic [1:0] HALT_NONE     = 2'd0;
    localparam logic [1:0] HALT_EBREAK   = 2'd1;
    localparam logic [1:0] HALT_ILLEGAL  = 2'd2;
    localparam logic [1:0] HALT_MISALIGN = 2'd3;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

    function automatic logic pc_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/npc_perf_cnt.sv
// Cycle and retired-instruction counters. freeze overrides both enables so
// the counts stay put once the core has stopped.
module npc_perf_cnt #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cycle_en,
    input  logic             retire_en,
    input  logic             freeze,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else if (!freeze) begin
            // Both counters wrap naturally modulo 2^CNT_W.
            if (cycle_en) begin
                cycle_cnt <= cycle_cnt + CNT_ONE;
            end
            if (retire_en) begin
                instret_cnt <= instret_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/npc_seq_ctrl.sv
// Multi-cycle sequencer for the NPC core: owns pc/inst and steps each
// instruction through fetch, decode, execute, memory and write-back.
module npc_seq_ctrl
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    // Handshakes: a request transfers on the cycle valid and ready are both
    // high at the rising edge; valid is held until then. Responses are
    // single-cycle pulses honoured only in the matching wait state.
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    input  logic             ifu_rsp_valid,
    input  logic [31:0]      ifu_rsp_inst,
    output logic [31:0]      pc,
    output logic [31:0]      inst,
    input  logic             dec_mem_rd,
    input  logic             dec_mem_wr,
    input  logic             dec_rf_wen,
    input  logic             dec_stop,
    input  logic             dec_illegal,
    input  logic [31:0]      exu_next_pc,
    output logic             lsu_req_valid,
    input  logic             lsu_req_ready,
    input  logic             lsu_rsp_valid,
    output logic             rf_we,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
    output npc_state_e       state_dbg
);

    npc_state_e  state_q, state_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] pc_q;
    logic [31:0] inst_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cause_q <= HALT_NONE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_q == ST_FETCH_WAIT && ifu_rsp_valid) begin
                inst_q <= ifu_rsp_inst;
            end
            if (state_q == ST_WB) begin
                pc_q <= exu_next_pc;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        rf_we         = 1'b0;
        halted        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH_REQ;
            end
            ST_FETCH_REQ: begin
                ifu_req_valid = 1'b1;
                if (ifu_req_ready) begin
                    state_d = ST_FETCH_WAIT;
                end
            end
            ST_FETCH_WAIT: begin
                if (ifu_rsp_valid) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // ebreak wins over illegal when the decoder flags both.
                if (dec_stop) begin
                    state_d = ST_HALT;
                    cause_d = HALT_EBREAK;
                end else if (dec_illegal) begin
                    state_d = ST_HALT;
                    cause_d = HALT_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!pc_aligned(exu_next_pc)) begin
                    state_d = ST_HALT;
                    cause_d = HALT_MISALIGN;
                end else if (dec_mem_rd || dec_mem_wr) begin
                    state_d = ST_MEM_REQ;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM_REQ: begin
                lsu_req_valid = 1'b1;
                if (lsu_req_ready) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (lsu_rsp_valid) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                // Stores never write rd even if the decoder reports rf_wen.
                rf_we   = dec_rf_wen & ~dec_mem_wr;
                state_d = ST_FETCH_REQ;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    npc_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .cycle_en    (1'b1),
        .retire_en   (state_q == ST_WB),
        .freeze      (state_q == ST_HALT),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    assign pc         = pc_q;
    assign inst       = inst_q;
    assign halt_cause = cause_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Directed bench for npc_seq_ctrl: walks instructions cycle by cycle and
// compares outputs against hand-computed values.
module tb_npc_seq_ctrl;
    import npc_pkg::*;

    localparam int CNT_W = 64;
    localparam logic [31:0] RPC = 32'h8000_0000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ifu_req_valid;
    logic             ifu_req_ready = 1'b1;
    logic             ifu_rsp_valid = 1'b0;
    logic [31:0]      ifu_rsp_inst = '0;
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic             dec_mem_rd = 1'b0;
    logic             dec_mem_wr = 1'b0;
    logic             dec_rf_wen = 1'b0;
    logic             dec_stop = 1'b0;
    logic             dec_illegal = 1'b0;
    logic [31:0]      exu_next_pc = RPC + 32'd4;
    logic             lsu_req_valid;
    logic             lsu_req_ready = 1'b0;
    logic             lsu_rsp_valid = 1'b0;
    logic             rf_we;
    logic             halted;
    logic [1:0]       halt_cause;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;
    npc_state_e       state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int rf_pulses = 0;
    int base;

    always #5 clk = ~clk;

    // rf_we sampled at the active edge is the value held through the WB cycle.
    always @(posedge clk) if (rf_we) rf_pulses++;

    npc_seq_ctrl #(.RESET_PC(RPC), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_inst  (ifu_rsp_inst),
        .pc            (pc),
        .inst          (inst),
        .dec_mem_rd    (dec_mem_rd),
        .dec_mem_wr    (dec_mem_wr),
        .dec_rf_wen    (dec_rf_wen),
        .dec_stop      (dec_stop),
        .dec_illegal   (dec_illegal),
        .exu_next_pc   (exu_next_pc),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .rf_we         (rf_we),
        .halted        (halted),
        .halt_cause    (halt_cause),
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt),
        .state_dbg     (state_dbg)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_dec(input logic rd, input logic wr, input logic wen,
                           input logic stp, input logic ill, input logic [31:0] npc);
        dec_mem_rd  = rd;
        dec_mem_wr  = wr;
        dec_rf_wen  = wen;
        dec_stop    = stp;
        dec_illegal = ill;
        exu_next_pc = npc;
    endtask

    // Leaves the bench at the negedge right after rst_n is released (IDLE).
    task automatic do_reset();
        rst_n = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        tick();
        tick();
        check("rst_state", state_dbg, ST_IDLE);
        check("rst_pc", pc, RPC);
        check("rst_cyc", cycle_cnt, 64'd0);
        rst_n = 1'b1;
    endtask

    // Entered at a negedge in FETCH_REQ; returns at the negedge in DECODE.
    task automatic do_fetch(input logic [31:0] w);
        ifu_req_ready = 1'b1;
        check("fetch_req_valid", ifu_req_valid, 1'b1);
        tick();
        check("fetch_wait_state", state_dbg, ST_FETCH_WAIT);
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = w;
        tick();
        ifu_rsp_valid = 1'b0;
        check("decode_inst", inst, w);
    endtask

    initial begin
        // Full reset state, including all outputs.
        tick();
        check("rst_inst", inst, 32'd0);
        check("rst_outs", {ifu_req_valid, lsu_req_valid, rf_we, halted, halt_cause}, 6'd0);
        check("rst_instret", instret_cnt, 64'd0);
        do_reset();

        // ALU instruction, stray rsp while in FETCH_REQ is ignored.
        set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, RPC + 32'd4);
        ifu_req_ready = 1'b1;
        tick();
        check("t1_first_req", ifu_req_valid, 1'b1);
        check("t1_cyc_idle", cycle_cnt, 64'd1);
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = 32'h0050_0093;
        tick();
        check("t1_fw", state_dbg, ST_FETCH_WAIT);
        tick();
        ifu_rsp_valid = 1'b0;
        check("t1_inst", inst, 32'h0050_0093);
        tick();
        check("t1_exec", state_dbg, ST_EXEC);
        check("t1_no_we_exec", rf_we, 1'b0);
        tick();
        check("t1_we_wb", rf_we, 1'b1);
        check("t1_pc_pre_wb", pc, RPC);
        tick();
        check("t1_pc", pc, 32'h8000_0004);
        check("t1_instret", instret_cnt, 64'd1);
        check("t1_refetch", ifu_req_valid, 1'b1);
        check("t1_we_off", rf_we, 1'b0);
        check("t1_cyc", cycle_cnt, 64'd6);

        // Load with a slow LSU: ready after 3 stall cycles, rsp 2 cycles later.
        do_reset();
        set_dec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, RPC + 32'd4);
        lsu_req_ready = 1'b0;
        base = rf_pulses;
        tick();
        do_fetch(32'h0000_a103);
        tick();
        check("t2_exec", state_dbg, ST_EXEC);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t2_lsu_valid_held", lsu_req_valid, 1'b1);
            if (i == 3) lsu_req_ready = 1'b1;
            tick();
        end
        lsu_req_ready = 1'b0;
        check("t2_mem_wait", state_dbg, ST_MEM_WAIT);
        check("t2_lsu_valid_drop", lsu_req_valid, 1'b0);
        tick();
        lsu_rsp_valid = 1'b1;
        tick();
        lsu_rsp_valid = 1'b0;
        check("t2_wb_we", rf_we, 1'b1);
        tick();
        check("t2_we_once", rf_pulses - base, 1);
        check("t2_instret", instret_cnt, 64'd1);
        check("t2_cyc", cycle_cnt, 64'd12);
        check("t2_pc", pc, 32'h8000_0004);

        // Store with rf_wen set: no write, pc advances, 7 cycles.
        set_dec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0008);
        lsu_req_ready = 1'b1;
        base = rf_pulses;
        do_fetch(32'h0020_a023);
        tick();
        tick();
        check("t3_mem_req", lsu_req_valid, 1'b1);
        tick();
        lsu_rsp_valid = 1'b1;
        tick();
        lsu_rsp_valid = 1'b0;
        check("t3_wb_state", state_dbg, ST_WB);
        check("t3_wb_no_we", rf_we, 1'b0);
        tick();
        check("t3_no_pulse", rf_pulses - base, 0);
        check("t3_pc", pc, 32'h8000_0008);
        check("t3_instret", instret_cnt, 64'd2);
        check("t3_cyc", cycle_cnt, 64'd19);

        // ebreak with illegal also flagged: cause 1, everything frozen.
        set_dec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_000c);
        do_fetch(32'h0010_0073);
        tick();
        check("t4_halted", halted, 1'b1);
        check("t4_cause", halt_cause, HALT_EBREAK);
        check("t4_cyc", cycle_cnt, 64'd22);
        for (int i = 0; i < 100; i++) begin
            ifu_rsp_valid = 1'($urandom_range(0, 1));
            lsu_rsp_valid = 1'($urandom_range(0, 1));
            ifu_rsp_inst  = $urandom;
            tick();
        end
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        check("t4_cyc_frozen", cycle_cnt, 64'd22);
        check("t4_instret", instret_cnt, 64'd2);
        check("t4_pc", pc, 32'h8000_0008);
        check("t4_inst", inst, 32'h0010_0073);
        check("t4_quiet", {ifu_req_valid, lsu_req_valid, rf_we, halted}, 4'b0001);

        // Misaligned next-PC: halt from EXEC, nothing retired.
        do_reset();
        set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0102);
        base = rf_pulses;
        tick();
        do_fetch(32'h1000_006f);
        tick();
        tick();
        check("t5_state", state_dbg, ST_HALT);
        check("t5_cause", halt_cause, HALT_MISALIGN);
        check("t5_pc", pc, RPC);
        check("t5_instret", instret_cnt, 64'd0);
        tick();
        check("t5_no_we", rf_pulses - base, 0);

        // Illegal alone: cause 2.
        do_reset();
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RPC + 32'd4);
        tick();
        do_fetch(32'hffff_ffff);
        tick();
        check("t6_cause", halt_cause, HALT_ILLEGAL);
        check("t6_cyc", cycle_cnt, 64'd4);

        // Reset while in MEM_WAIT, then a dropped LSU response after release.
        do_reset();
        set_dec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, RPC + 32'd4);
        lsu_req_ready = 1'b1;
        tick();
        do_fetch(32'h0000_a103);
        tick();
        tick();
        tick();
        check("t7_in_mem_wait", state_dbg, ST_MEM_WAIT);
        rst_n = 1'b0;
        #1;
        check("t7_async_idle", state_dbg, ST_IDLE);
        check("t7_async_pc", pc, RPC);
        check("t7_async_inst", inst, 32'd0);
        tick();
        lsu_rsp_valid = 1'b1;
        ifu_req_ready = 1'b0;
        rst_n = 1'b1;
        tick();
        check("t7_fetch_req", state_dbg, ST_FETCH_REQ);
        check("t7_pc", pc, RPC);
        tick();
        check("t7_hold_req", {ifu_req_valid, lsu_req_valid}, 2'b10);
        check("t7_still_fr", state_dbg, ST_FETCH_REQ);
        lsu_rsp_valid = 1'b0;
        ifu_req_ready = 1'b1;
        tick();
        check("t7_fw", state_dbg, ST_FETCH_WAIT);
        check("t7_instret", instret_cnt, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
